registro_desplazable: RTL and testbench
=======================================

Name: registro_desplazable

Overview:
- Synchronous universal shift register, WIDTH bits wide (4 by default).
- Supports serial shift, rotation and parallel load, selected by a 2-bit mode input and a direction input.
- Provides a registered serial output for cascading.
- Used as a general-purpose data-path register.

Parameters:
- WIDTH, 4, register width in bits (minimum 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- ENB  input  1  enable; 0 = hold Q and S_OUT.
- DIR  input  1  direction; 0 = left (towards MSB), 1 = right (towards LSB).
- S_IN  input  1  serial input bit, used in shift mode.
- MODO  input  2  operation select.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents (registered).
- S_OUT  output  1  serial output (registered).

Behaviour:
- All updates occur on the rising edge of clk only; no combinational path from inputs to outputs.
- Priority order: reset > ENB=0 > MODO decode.
- reset=1: Q <= 0 and S_OUT <= 0, regardless of ENB, MODO or D. Reset asserted mid-operation clears on the next edge.
- ENB=0 (reset=0): Q and S_OUT hold their values.
- ENB=1, MODO=00, shift:
  - DIR=0: Q <= {Q[WIDTH-2:0], S_IN}; S_OUT <= Q[WIDTH-1] (bit shifted out).
  - DIR=1: Q <= {S_IN, Q[WIDTH-1:1]}; S_OUT <= Q[0].
- ENB=1, MODO=01, rotate:
  - DIR=0: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; S_OUT <= Q[WIDTH-1].
  - DIR=1: Q <= {Q[0], Q[WIDTH-1:1]}; S_OUT <= Q[0].
  - S_IN is ignored.
- ENB=1, MODO=10, parallel load:
  - Q <= D; S_OUT <= 0.
  - DIR and S_IN are ignored.
  - Repeated load edges with a constant D leave Q unchanged.
- ENB=1, MODO=11, hold: Q and S_OUT keep their values.
- Latency: exactly one clock edge from input sampling to the visible Q/S_OUT change.
- S_OUT always reflects the value produced by the most recent enabled, non-hold operation.
- Wrap-around:
  - After WIDTH consecutive rotations in the same direction, Q returns to its original value.
  - After WIDTH shifts, Q is entirely S_IN-filled.
- Direction changes between cycles take effect on the next edge with no penalty.
- Any X/Z on the inputs is not required to be handled.

Test Plan:
- Reset: reset=1 for 1 edge with ENB=1, MODO=10, D=1101 -> Q=0000, S_OUT=0. Deassert reset -> the next edge loads Q=1101.
- Parallel load: ENB=1, MODO=10, DIR=1, S_IN=1, D=1101, run 8 edges -> Q=1101 and S_OUT=0 after every edge.
- Shift right: from Q=1101, MODO=00, DIR=1, S_IN=1 -> Q=1110, S_OUT=1; next edge -> Q=1111, S_OUT=0.
- Shift left: from Q=1101, MODO=00, DIR=0, S_IN=0 -> Q=1010, S_OUT=1; next edge -> Q=0100, S_OUT=1; next edge -> Q=1000, S_OUT=0.
- Rotate: from Q=1101, MODO=01, DIR=0 -> Q=1011, S_OUT=1; 3 more edges -> Q=1101. With DIR=1 from 1101 -> Q=1110, S_OUT=1.
- Enable/hold: Q=1101, S_OUT=1. Set ENB=0 with MODO=00, then ENB=1 with MODO=11, over 3 edges each -> Q=1101 and S_OUT=1 unchanged throughout.

Source files
------------

// File: rtl/registro_desplazable.sv
// rtl/registro_desplazable.sv - universal shift register with shift, rotate, load and registered serial output
module registro_desplazable #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT
);

    localparam logic [1:0] MODO_SHIFT  = 2'b00;
    localparam logic [1:0] MODO_ROTATE = 2'b01;
    localparam logic [1:0] MODO_LOAD   = 2'b10;
    localparam logic [1:0] MODO_HOLD   = 2'b11;

    logic [WIDTH-1:0] q_next;
    logic             s_out_next;

    // S_OUT always carries the bit that leaves the register on shift/rotate.
    always_comb begin
        q_next     = Q;
        s_out_next = S_OUT;
        case (MODO)
            MODO_SHIFT: begin
                if (DIR) begin
                    q_next     = {S_IN, Q[WIDTH-1:1]};
                    s_out_next = Q[0];
                end else begin
                    q_next     = {Q[WIDTH-2:0], S_IN};
                    s_out_next = Q[WIDTH-1];
                end
            end
            MODO_ROTATE: begin
                if (DIR) begin
                    q_next     = {Q[0], Q[WIDTH-1:1]};
                    s_out_next = Q[0];
                end else begin
                    q_next     = {Q[WIDTH-2:0], Q[WIDTH-1]};
                    s_out_next = Q[WIDTH-1];
                end
            end
            MODO_LOAD: begin
                q_next     = D;
                s_out_next = 1'b0;
            end
            MODO_HOLD: begin
                q_next     = Q;
                s_out_next = S_OUT;
            end
            default: begin
                q_next     = Q;
                s_out_next = S_OUT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q     <= '0;
            S_OUT <= 1'b0;
        end else if (ENB) begin
            Q     <= q_next;
            S_OUT <= s_out_next;
        end
    end

endmodule

// File: tb/tb_registro_desplazable.sv
// tb/tb_registro_desplazable.sv - self-checking bench for registro_desplazable
module tb_registro_desplazable;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ENB;
    logic             DIR;
    logic             S_IN;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             S_OUT;

    int passed = 0;
    int total  = 0;

    int exp_q;
    int exp_s;

    registro_desplazable #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .ENB   (ENB),
        .DIR   (DIR),
        .S_IN  (S_IN),
        .MODO  (MODO),
        .D     (D),
        .Q     (Q),
        .S_OUT (S_OUT)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic r, input logic e, input logic dir, input logic sin,
                         input logic [1:0] m, input logic [WIDTH-1:0] d);
        reset = r;
        ENB   = e;
        DIR   = dir;
        S_IN  = sin;
        MODO  = m;
        D     = d;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
    endtask

    // Reference: register contents as an integer; shifting is *2 / /2 modulo 2**WIDTH.
    task automatic model_update();
        int full;
        int half;
        int msb;
        int lsb;
        full = 2 ** WIDTH;
        half = full / 2;
        msb  = exp_q / half;
        lsb  = exp_q % 2;
        if (reset) begin
            exp_q = 0;
            exp_s = 0;
        end else if (ENB) begin
            if (MODO == 2'd0) begin
                exp_s = DIR ? lsb : msb;
                exp_q = DIR ? (exp_q / 2 + int'(S_IN) * half) : ((exp_q * 2) % full + int'(S_IN));
            end else if (MODO == 2'd1) begin
                exp_s = DIR ? lsb : msb;
                exp_q = DIR ? (exp_q / 2 + lsb * half) : ((exp_q * 2) % full + msb);
            end else if (MODO == 2'd2) begin
                exp_q = int'(D);
                exp_s = 0;
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1101);
        clock_edge();
        total++;
        if (Q !== 4'b0000 || S_OUT !== 1'b0)
            $display("FAIL reset: Q=%b S_OUT=%b, required Q=0000 S_OUT=0", Q, S_OUT);
        else passed++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1101);
        clock_edge();
        total++;
        if (Q !== 4'b1101 || S_OUT !== 1'b0)
            $display("FAIL reset_release_load: Q=%b S_OUT=%b, required Q=1101 S_OUT=0", Q, S_OUT);
        else passed++;
    endtask

    task automatic test_load();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 4'b1101);
        for (int i = 0; i < 8; i++) begin
            clock_edge();
            total++;
            if (Q !== 4'b1101 || S_OUT !== 1'b0)
                $display("FAIL load_%0d: Q=%b S_OUT=%b, required Q=1101 S_OUT=0", i, Q, S_OUT);
            else passed++;
        end
    endtask

    task automatic test_shift_right();
        logic [WIDTH-1:0] tq [2];
        logic             ts [2];
        tq = '{4'b1110, 4'b1111};
        ts = '{1'b1, 1'b0};
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1101);
        clock_edge();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            clock_edge();
            total++;
            if (Q !== tq[i] || S_OUT !== ts[i])
                $display("FAIL shift_right_%0d: Q=%b S_OUT=%b, required Q=%b S_OUT=%b", i, Q, S_OUT, tq[i], ts[i]);
            else passed++;
        end
    endtask

    task automatic test_shift_left();
        logic [WIDTH-1:0] tq [3];
        logic             ts [3];
        tq = '{4'b1010, 4'b0100, 4'b1000};
        ts = '{1'b1, 1'b1, 1'b0};
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1101);
        clock_edge();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            total++;
            if (Q !== tq[i] || S_OUT !== ts[i])
                $display("FAIL shift_left_%0d: Q=%b S_OUT=%b, required Q=%b S_OUT=%b", i, Q, S_OUT, tq[i], ts[i]);
            else passed++;
        end
    endtask

    task automatic test_rotate();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1101);
        clock_edge();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0000);
        clock_edge();
        total++;
        if (Q !== 4'b1011 || S_OUT !== 1'b1)
            $display("FAIL rotate_left: Q=%b S_OUT=%b, required Q=1011 S_OUT=1", Q, S_OUT);
        else passed++;
        for (int i = 0; i < 3; i++) clock_edge();
        total++;
        if (Q !== 4'b1101 || S_OUT !== 1'b1)
            $display("FAIL rotate_left_wrap: Q=%b S_OUT=%b, required Q=1101 S_OUT=1", Q, S_OUT);
        else passed++;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 4'b0000);
        clock_edge();
        total++;
        if (Q !== 4'b1110 || S_OUT !== 1'b1)
            $display("FAIL rotate_right: Q=%b S_OUT=%b, required Q=1110 S_OUT=1", Q, S_OUT);
        else passed++;
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1101);
        clock_edge();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 4'b0000);
        for (int i = 0; i < 4; i++) clock_edge();
        total++;
        if (Q !== 4'b1101 || S_OUT !== 1'b1)
            $display("FAIL hold_setup: Q=%b S_OUT=%b, required Q=1101 S_OUT=1", Q, S_OUT);
        else passed++;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            total++;
            if (Q !== 4'b1101 || S_OUT !== 1'b1)
                $display("FAIL hold_enb0_%0d: Q=%b S_OUT=%b, required Q=1101 S_OUT=1", i, Q, S_OUT);
            else passed++;
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            clock_edge();
            total++;
            if (Q !== 4'b1101 || S_OUT !== 1'b1)
                $display("FAIL hold_modo11_%0d: Q=%b S_OUT=%b, required Q=1101 S_OUT=1", i, Q, S_OUT);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] start;
        logic             dir;
        logic             fill;
        for (int n = 0; n < 8; n++) begin
            start = WIDTH'($urandom);
            dir   = 1'($urandom);
            fill  = 1'($urandom);
            drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, start);
            clock_edge();
            drive(1'b0, 1'b1, dir, fill, 2'b01, 4'b0000);
            for (int i = 0; i < WIDTH; i++) clock_edge();
            total++;
            if (Q !== start)
                $display("FAIL wrap_rotate_%0d: Q=%b, required %b", n, Q, start);
            else passed++;
            drive(1'b0, 1'b1, dir, fill, 2'b00, 4'b0000);
            for (int i = 0; i < WIDTH; i++) clock_edge();
            total++;
            if (Q !== {WIDTH{fill}})
                $display("FAIL wrap_shift_%0d: Q=%b, required %b", n, Q, {WIDTH{fill}});
            else passed++;
        end
    endtask

    task automatic test_random();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
        clock_edge();
        exp_q = 0;
        exp_s = 0;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 5) != 0), 1'($urandom),
                  1'($urandom), 2'($urandom), WIDTH'($urandom));
            model_update();
            clock_edge();
            total++;
            if (Q !== WIDTH'(exp_q) || S_OUT !== 1'(exp_s))
                $display("FAIL random_%0d: Q=%b S_OUT=%b, required Q=%b S_OUT=%b",
                         i, Q, S_OUT, WIDTH'(exp_q), 1'(exp_s));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'b0110);
        clock_edge();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'b0000);
        clock_edge();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b0000);
        clock_edge();
        total++;
        if (Q !== 4'b0110 || S_OUT !== 1'b1)
            $display("FAIL dir_change: Q=%b S_OUT=%b, required Q=0110 S_OUT=1", Q, S_OUT);
        else passed++;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0000);
        clock_edge();
        total++;
        if (Q !== 4'b0000 || S_OUT !== 1'b0)
            $display("FAIL midop_reset: Q=%b S_OUT=%b, required Q=0000 S_OUT=0", Q, S_OUT);
        else passed++;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000);
        test_reset();
        test_load();
        test_shift_right();
        test_shift_left();
        test_rotate();
        test_hold();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
